mult_error_monitor: RTL

//  Receiving end of the if_multiplier operand/product interface: samples operand pairs and the

---
 rtl/mult_pkg.sv | 8 +
 rtl/mult_err_dist.sv | 35 +++
 rtl/mult_error_monitor.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier error monitor.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 16;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mon_state_t;

endpackage

// File: rtl/mult_err_dist.sv
// Registered exact product and absolute distance to the approximate product.
module mult_err_dist
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_vld,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [2*WIDTH-1:0]   i_approx,
    output logic                 o_vld,
    output logic [2*WIDTH-1:0]   o_dist
);

    logic [2*WIDTH-1:0] w_exact;
    logic [2*WIDTH-1:0] w_dist;

    assign w_exact = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
    assign w_dist  = (w_exact >= i_approx) ? (w_exact - i_approx) : (i_approx - w_exact);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld  <= 1'b0;
            o_dist <= '0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_dist <= w_dist;
            end
        end
    end

endmodule

// File: rtl/mult_error_monitor.sv
// Samples multiplier operands and approximate product, accumulates error statistics per run.
module mult_error_monitor
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SUM_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     in1,
    input  logic [WIDTH-1:0]     in2,
    input  logic [2*WIDTH-1:0]   approx_prod,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     sample_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [2*WIDTH-1:0]   max_err,
    output logic [SUM_W-1:0]     sum_err
);

    mon_state_t          r_state;
    logic [CNT_W-1:0]    r_n;
    logic                r_s1_vld;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_approx;

    logic                w_accept;
    logic                w_start;
    logic                w_last;
    logic                w_s2_vld;
    logic [2*WIDTH-1:0]  w_dist;
    logic [SUM_W:0]      w_sum_ext;

    assign w_accept  = valid_i && ready_o;
    assign w_start   = start_i && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = ((sample_cnt + CNT_W'(1)) == r_n);
    assign w_sum_ext = {1'b0, sum_err} + (SUM_W+1)'(w_dist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_approx <= '0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_a      <= in1;
                r_b      <= in2;
                r_approx <= approx_prod;
            end
        end
    end

    mult_err_dist #(.WIDTH(WIDTH)) u_dist (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vld    (r_s1_vld),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_approx (r_approx),
        .o_vld    (w_s2_vld),
        .o_dist   (w_dist)
    );

    // ready_o is registered: it drops on the same edge that accepts the N-th sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_n        <= '0;
            sample_cnt <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start_i) begin
                        r_n        <= num_samples;
                        sample_cnt <= '0;
                        if (num_samples == '0) begin
                            r_state <= DONE;
                            done_o  <= 1'b1;
                            busy_o  <= 1'b0;
                            ready_o <= 1'b0;
                        end else begin
                            r_state <= RUN;
                            done_o  <= 1'b0;
                            busy_o  <= 1'b1;
                            ready_o <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DRAIN;
                            ready_o <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // Once S1 is empty the last sample sits in S2 and commits on this edge.
                    if (!r_s1_vld) begin
                        r_state <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            max_err <= '0;
            sum_err <= '0;
        end else if (w_start) begin
            err_cnt <= '0;
            max_err <= '0;
            sum_err <= '0;
        end else if (w_s2_vld) begin
            if (w_dist != '0) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (w_dist > max_err) begin
                max_err <= w_dist;
            end
            sum_err <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
        end
    end

endmodule
